// File: rtl/flip_variable_selector_pkg.sv
// wsat_pkg: types and constants shared across the WSAT datapath.
//   VAR_W_DEF / CNT_W_DEF : default variable-index and break-count widths
//   sel_state_t           : flip-selector FSM state encoding
//   LFSR_TAPS             : 16-bit Fibonacci tap mask (taps 16,14,13,11)
package wsat_pkg;

    localparam int VAR_W_DEF = 10;
    localparam int CNT_W_DEF = 5;

    // Bit k set means register bit k (tap k+1) feeds the XOR.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DECIDE,
        S_DONE
    } sel_state_t;

endpackage

// File: rtl/flip_variable_selector_lfsr.sv
// wsat_lfsr16: free-running 16-bit Fibonacci LFSR.
//   clk_i  : clock
//   rst_i  : synchronous active-low reset, loads SEED
//   lfsr_o : current LFSR state, advances every cycle out of reset
module wsat_lfsr16
    import wsat_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/flip_variable_selector.sv
// flip_variable_selector: collects the candidates of one unsatisfied clause
// and picks the variable to flip with the WalkSAT rule.
//   clk, rst (sync, active-low)        : clock / reset
//   start, noise_thresh                : begin selection, random-walk prob x256
//   cand_valid/ready/var/count/last    : candidate stream from break_value_counter
//   busy, done                         : status, one-cycle result pulse
//   flip_var, flip_free, flip_random   : selected variable and how it was chosen
//   overflow                           : clause had more than NUM_LIT candidates
module flip_variable_selector
    import wsat_pkg::*;
#(
    parameter int          NUM_LIT = 8,
    parameter int          VAR_W   = VAR_W_DEF,
    parameter int          CNT_W   = CNT_W_DEF,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       noise_thresh,
    input  logic             cand_valid,
    output logic             cand_ready,
    input  logic [VAR_W-1:0] cand_var,
    input  logic [CNT_W-1:0] cand_count,
    input  logic             cand_last,
    output logic             busy,
    output logic             done,
    output logic [VAR_W-1:0] flip_var,
    output logic             flip_free,
    output logic             flip_random,
    output logic             overflow
);

    localparam int LW = $clog2(NUM_LIT);
    localparam int NW = LW + 1;
    localparam int PW = 8 + NW;

    sel_state_t       state_q;
    logic [NW-1:0]    n_q;
    logic [CNT_W-1:0] min_cnt_q;
    logic [VAR_W-1:0] min_var_q;
    logic [7:0]       thr_q;
    logic             ovf_pend_q;
    logic [VAR_W-1:0] buf_q [NUM_LIT];

    logic             done_q;
    logic [VAR_W-1:0] flip_var_q;
    logic             flip_free_q;
    logic             flip_random_q;
    logic             overflow_q;

    logic [15:0]      lfsr;
    logic [PW-1:0]    prod;
    logic [LW-1:0]    slot;
    logic             rnd_hit;

    wsat_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk_i  (clk),
        .rst_i  (rst),
        .lfsr_o (lfsr)
    );

    // Scaling an 8-bit draw by n keeps the random slot strictly below n.
    // thr=255 is treated as "always walk" so a saturated threshold never
    // falls back to greedy when lfsr[7:0] happens to be 255.
    always_comb begin
        prod    = PW'(lfsr[15:8]) * PW'(n_q);
        slot    = LW'(prod >> 8);
        rnd_hit = (thr_q == 8'hFF) || (lfsr[7:0] < thr_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            n_q           <= '0;
            min_cnt_q     <= '1;
            min_var_q     <= '0;
            thr_q         <= '0;
            ovf_pend_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_LIT; i++) buf_q[i] <= '0;
            done_q        <= 1'b0;
            flip_var_q    <= '0;
            flip_free_q   <= 1'b0;
            flip_random_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        n_q        <= '0;
                        min_cnt_q  <= '1;
                        thr_q      <= noise_thresh;
                        ovf_pend_q <= 1'b0;
                        state_q    <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (cand_valid) begin
                        buf_q[n_q[LW-1:0]] <= cand_var;
                        n_q                <= n_q + 1'b1;
                        // First candidate always loads the tracker so a clause
                        // whose counts are all-ones still yields a valid min_var.
                        if (n_q == '0 || cand_count < min_cnt_q) begin
                            min_cnt_q <= cand_count;
                            min_var_q <= cand_var;
                        end
                        if (cand_last || n_q == NW'(NUM_LIT - 1)) begin
                            ovf_pend_q <= ~cand_last;
                            state_q    <= S_DECIDE;
                        end
                    end
                end
                S_DECIDE: begin
                    if (min_cnt_q == '0) begin
                        flip_var_q    <= min_var_q;
                        flip_free_q   <= 1'b1;
                        flip_random_q <= 1'b0;
                    end else if (rnd_hit) begin
                        flip_var_q    <= buf_q[slot];
                        flip_free_q   <= 1'b0;
                        flip_random_q <= 1'b1;
                    end else begin
                        flip_var_q    <= min_var_q;
                        flip_free_q   <= 1'b0;
                        flip_random_q <= 1'b0;
                    end
                    overflow_q <= ovf_pend_q;
                    done_q     <= 1'b1;
                    state_q    <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cand_ready  = (state_q == S_COLLECT);
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign flip_var    = flip_var_q;
    assign flip_free   = flip_free_q;
    assign flip_random = flip_random_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_flip_variable_selector.sv
// Self-checking bench for flip_variable_selector: directed WalkSAT scenarios,
// a long random-walk run with distribution bounds, and randomized clauses
// compared against a behavioural model of the selection rule.
module tb_flip_variable_selector;

    localparam int          NUM_LIT = 8;
    localparam int          VAR_W   = 10;
    localparam int          CNT_W   = 5;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic             clk;
    logic             rst;
    logic             start;
    logic [7:0]       noise_thresh;
    logic             cand_valid;
    logic             cand_ready;
    logic [VAR_W-1:0] cand_var;
    logic [CNT_W-1:0] cand_count;
    logic             cand_last;
    logic             busy;
    logic             done;
    logic [VAR_W-1:0] flip_var;
    logic             flip_free;
    logic             flip_random;
    logic             overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [VAR_W-1:0] cv [16];
    logic [CNT_W-1:0] cc [16];

    logic [15:0] lfsr_m;
    logic [15:0] lfsr_prev;

    flip_variable_selector #(
        .NUM_LIT (NUM_LIT),
        .VAR_W   (VAR_W),
        .CNT_W   (CNT_W),
        .SEED    (SEED)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .noise_thresh (noise_thresh),
        .cand_valid   (cand_valid),
        .cand_ready   (cand_ready),
        .cand_var     (cand_var),
        .cand_count   (cand_count),
        .cand_last    (cand_last),
        .busy         (busy),
        .done         (done),
        .flip_var     (flip_var),
        .flip_free    (flip_free),
        .flip_random  (flip_random),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference generator: x^16+x^14+x^13+x^11 shifted in at the LSB.
    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    // lfsr_prev holds the value the generator had during the previous cycle.
    always @(posedge clk) begin
        lfsr_prev = lfsr_m;
        lfsr_m    = (!rst) ? SEED : lfsr_step(lfsr_m);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one clause from cv/cc starting at the current negedge and checks
    // the handshake, latency and result against the WalkSAT rule.
    task automatic run_clause(input logic [7:0] thr, input int nc, input bit use_last,
                              input bit poke_start, output logic [VAR_W-1:0] got_var,
                              output bit got_rnd);
        int          nacc;
        bit          last_acc;
        int          lat;
        logic [15:0] lv;
        int          mn;
        int          mv;
        int          ev;
        bit          efree;
        bit          ernd;
        start        = 1'b1;
        noise_thresh = thr;
        @(negedge clk);
        start        = 1'b0;
        noise_thresh = 8'($urandom);
        check("busy_collect", busy, 1);
        nacc     = 0;
        last_acc = 1'b0;
        for (int i = 0; i < nc; i++) begin
            cand_valid = 1'b1;
            cand_var   = cv[i];
            cand_count = cc[i];
            cand_last  = use_last && (i == nc - 1);
            if (poke_start && i == 1) start = 1'b1;
            check("cand_ready", cand_ready, (i < NUM_LIT) ? 1 : 0);
            if (i >= NUM_LIT) break;
            nacc++;
            last_acc = cand_last;
            @(negedge clk);
            start = 1'b0;
        end
        start = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check("done_latency", lat, 1);
        cand_valid = 1'b0;
        cand_last  = 1'b0;
        lv = lfsr_prev;
        mn = 0;
        mv = 0;
        for (int k = 0; k < nacc; k++) begin
            if (k == 0 || int'(cc[k]) < mn) begin
                mn = int'(cc[k]);
                mv = int'(cv[k]);
            end
        end
        if (mn == 0) begin
            ev = mv; efree = 1'b1; ernd = 1'b0;
        end else if (thr == 8'hFF || lv[7:0] < thr) begin
            ev = int'(cv[(int'(lv[15:8]) * nacc) / 256]); efree = 1'b0; ernd = 1'b1;
        end else begin
            ev = mv; efree = 1'b0; ernd = 1'b0;
        end
        check("flip_var", flip_var, ev);
        check("flip_free", flip_free, efree);
        check("flip_random", flip_random, ernd);
        check("overflow", overflow, (nacc == NUM_LIT && !last_acc) ? 1 : 0);
        got_var = flip_var;
        got_rnd = flip_random;
        @(negedge clk);
        check("done_pulse", done, 0);
        check("idle_after", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ready"}, cand_ready, 0);
        check({tag, "_var"}, flip_var, 0);
        check({tag, "_free"}, flip_free, 0);
        check({tag, "_rnd"}, flip_random, 0);
        check({tag, "_ovf"}, overflow, 0);
    endtask

    initial begin
        logic [VAR_W-1:0] gv;
        bit               gr;
        int               hist [3];
        int               nc;
        bit               ul;

        rst          = 1'b0;
        start        = 1'b0;
        noise_thresh = '0;
        cand_valid   = 1'b0;
        cand_var     = '0;
        cand_count   = '0;
        cand_last    = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Free move: earliest zero-break variable wins even at thr=255.
        cv[0] = 5;  cc[0] = 3;
        cv[1] = 9;  cc[1] = 0;
        cv[2] = 12; cc[2] = 0;
        run_clause(8'd255, 3, 1'b1, 1'b0, gv, gr);
        check("free_var_const", gv, 9);

        // Greedy with a tie: earliest minimum kept.
        cv[0] = 3;  cc[0] = 4;
        cv[1] = 7;  cc[1] = 2;
        cv[2] = 11; cc[2] = 2;
        run_clause(8'd0, 3, 1'b1, 1'b0, gv, gr);
        check("greedy_var_const", gv, 7);
        check("greedy_rnd_const", gr, 0);

        // Overflow: 9 offered, 8 accepted, minimum is the 8th (count 2).
        for (int i = 0; i < 9; i++) begin
            cv[i] = VAR_W'(100 + i);
            cc[i] = CNT_W'(9 - i);
        end
        run_clause(8'd0, 9, 1'b0, 1'b0, gv, gr);
        check("ovf_var_const", gv, 107);

        // Next clause clears overflow; start also poked mid-COLLECT.
        cv[0] = 20; cc[0] = 6;
        cv[1] = 21; cc[1] = 5;
        cv[2] = 22; cc[2] = 7;
        run_clause(8'd0, 3, 1'b1, 1'b1, gv, gr);
        check("poke_var_const", gv, 21);

        // cand_valid while idle must not start or disturb anything.
        cand_valid = 1'b1;
        cand_var   = 10'h3FF;
        cand_count = '0;
        cand_last  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_ready", cand_ready, 0);
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
        end
        cand_valid = 1'b0;
        cand_last  = 1'b0;
        run_clause(8'd0, 3, 1'b1, 1'b0, gv, gr);
        check("idle_var_const", gv, 21);

        // Reset mid-clause after 2 of 3 candidates.
        start        = 1'b1;
        noise_thresh = 8'd0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cand_valid = 1'b1;
            cand_var   = cv[i];
            cand_count = cc[i];
            @(negedge clk);
        end
        cand_valid = 1'b0;
        rst        = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b1;
        @(negedge clk);
        check("midrst_nodone", done, 0);
        cv[0] = 30; cc[0] = 3;
        cv[1] = 31; cc[1] = 1;
        run_clause(8'd0, 2, 1'b1, 1'b0, gv, gr);
        check("fresh_var_const", gv, 31);

        // Random walk over equal counts: every pick random, spread over slots.
        hist[0] = 0; hist[1] = 0; hist[2] = 0;
        cv[0] = 1; cc[0] = 1;
        cv[1] = 2; cc[1] = 1;
        cv[2] = 4; cc[2] = 1;
        for (int t = 0; t < 1000; t++) begin
            run_clause(8'd255, 3, 1'b1, 1'b0, gv, gr);
            check("walk_rnd", gr, 1);
            case (gv)
                10'd1:   hist[0]++;
                10'd2:   hist[1]++;
                10'd4:   hist[2]++;
                default: ;
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        for (int s = 0; s < 3; s++) begin
            check("walk_dist", (hist[s] >= 250 && hist[s] <= 420) ? 1 : 0, 1);
        end

        // Randomized clauses: arbitrary counts, thresholds, lengths.
        for (int t = 0; t < 300; t++) begin
            ul = 1'($urandom_range(0, 3) != 0);
            nc = ul ? $urandom_range(1, NUM_LIT) : $urandom_range(NUM_LIT, NUM_LIT + 2);
            for (int i = 0; i < nc; i++) begin
                cv[i] = VAR_W'($urandom);
                cc[i] = CNT_W'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            end
            run_clause(8'($urandom), nc, ul, 1'($urandom_range(0, 1)), gv, gr);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
